// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg
//   Shared types and constants for the UART receiver.
//   - rx_state_e   : receiver FSM states
//   - DEF_*        : default frame/oversampling parameters
//   - clog2()      : counter width helper (never returns less than 1)
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_OVERSAMPLE  = 16;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rx_core_sync_2ff.sv
// sync_2ff
//   Multi-stage flip-flop synchroniser for a single asynchronous bit.
//   Ports:
//     clk_i    in  system clock
//     rst_n_i  in  asynchronous active-low reset (chain loads RESET_VAL)
//     d_i      in  asynchronous input
//     q_o      out synchronised output (STAGES clocks of latency)
module sync_2ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1-style UART receiver using an oversampling tick. Each correctly framed
//   byte is presented on bus together with a one-cycle rx_done strobe; a low
//   stop bit produces a one-cycle frame_err strobe and leaves bus untouched.
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     dcom       in   serial line (idle high, asynchronous)
//     tick_in    in   OVERSAMPLE x baud enable pulse
//     bus        out  last good byte
//     rx_done    out  1-cycle pulse when bus updates
//     frame_err  out  1-cycle pulse on a low stop bit
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | line idle, waiting for a low sample
//   START | counting to mid start bit to reject glitches
//   DATA  | sampling DATA_BITS data bits at mid bit, LSB first
//   STOP  | sampling stop bit at mid bit
//   BREAK | stop bit was low; wait for line to return high
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dcom,
  input  logic                 tick_in,
  output logic [DATA_BITS-1:0] bus,
  output logic                 rx_done,
  output logic                 frame_err
);

  localparam int TW = clog2(OVERSAMPLE);
  localparam int BW = clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] bus_q, bus_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;

  sync_2ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .d_i     (dcom),
    .q_o     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      bus_q       <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      bus_q       <= bus_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Everything advances only on tick cycles; strobes default low so they
  // are exactly one clock wide.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    bus_d       = bus_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (tick_in) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end

        START: begin
          if (tick_cnt_q == TICK_MID) begin
            if (!rx_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        STOP: begin
          // Returning to IDLE at mid stop bit lets a start edge that follows
          // immediately be caught even with a slightly fast transmitter.
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              bus_d     = shift_q;
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        BREAK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus       = bus_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
  import uart_rx_core_pkg::*;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dcom = 1'b1;
  logic       tick_in = 1'b0;
  logic [7:0] bus;
  logic       rx_done;
  logic       frame_err;

  int   checks = 0;
  int   failures = 0;
  int   out_cnt = 0;
  logic width_pending = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dcom      (dcom),
    .tick_in   (tick_in),
    .bus       (bus),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe is matched against the oldest expected event,
  // and the cycle after a strobe must be quiet.
  always @(negedge clk) begin
    if (width_pending) begin
      width_pending = 1'b0;
      checks++;
      if ((rx_done | frame_err) !== 1'b0) begin
        failures++;
        $display("FAIL pulse_width got rx_done=%0b frame_err=%0b want 0 0", rx_done, frame_err);
      end
    end else if (rst_n && (rx_done === 1'b1 || frame_err === 1'b1)) begin
      out_cnt++;
      width_pending = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got rx_done=%0b frame_err=%0b bus=%02h want none",
                 rx_done, frame_err, bus);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rx_done, frame_err, bus} !== {~mon_e.err, mon_e.err, mon_e.data}) begin
          failures++;
          $display("FAIL scoreboard got rx_done=%0b frame_err=%0b bus=%02h want rx_done=%0b frame_err=%0b bus=%02h",
                   rx_done, frame_err, bus, ~mon_e.err, mon_e.err, mon_e.data);
        end
      end
    end
  end

  task automatic do_tick();
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) tick_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    dcom = v;
    repeat (n) do_tick();
  endtask

  // pause_bit >= 0 freezes the tick for 100 clocks in the middle of that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int pause_bit);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == pause_bit) begin
        drive_bit(d[i], 8);
        repeat (100) @(negedge clk);
        drive_bit(d[i], 8);
      end else begin
        drive_bit(d[i], 16);
      end
    end
    drive_bit(stop_v, 16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dcom  = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus !== 8'h00) begin failures++; $display("FAIL reset_bus got %02h want 00", bus); end
    checks++;
    if ({rx_done, frame_err} !== 2'b00) begin
      failures++; $display("FAIL reset_strobes got %b want 00", {rx_done, frame_err});
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++; $display("FAIL reset_state got %0d want %0d", dut.state_q, IDLE);
    end
    rst_n = 1'b1;
    drive_bit(1'b1, 8);
  endtask

  task automatic test_good_frame();
    int n0;
    n0 = out_cnt;
    exp_q.push_back('{err: 1'b0, data: 8'hA5});
    send_frame(8'hA5, 1'b1, -1);
    drive_bit(1'b1, 4);
    checks++;
    if (out_cnt !== n0 + 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL good_frame_count got %0d want %0d", out_cnt - n0, 1);
    end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = out_cnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 20);
    checks++;
    if (out_cnt !== n0) begin failures++; $display("FAIL glitch_outputs got %0d want 0", out_cnt - n0); end
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++; $display("FAIL glitch_state got %0d want %0d", dut.state_q, IDLE);
    end
    checks++;
    if (bus !== 8'hA5) begin failures++; $display("FAIL glitch_bus got %02h want a5", bus); end
  endtask

  task automatic test_frame_err();
    int n0;
    n0 = out_cnt;
    exp_q.push_back('{err: 1'b1, data: 8'hA5});
    send_frame(8'h3C, 1'b0, -1);
    drive_bit(1'b0, 40);
    checks++;
    if (out_cnt !== n0 + 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL frame_err_count got %0d want 1", out_cnt - n0);
    end
    checks++;
    if (dut.state_q !== BREAK) begin
      failures++; $display("FAIL break_state got %0d want %0d", dut.state_q, BREAK);
    end
    drive_bit(1'b1, 20);
    checks++;
    if (dut.state_q !== IDLE || out_cnt !== n0 + 1) begin
      failures++; $display("FAIL break_exit got state=%0d outputs=%0d want state=%0d outputs=1",
                           dut.state_q, out_cnt - n0, IDLE);
    end
    checks++;
    if (bus !== 8'hA5) begin failures++; $display("FAIL frame_err_bus got %02h want a5", bus); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = out_cnt;
    exp_q.push_back('{err: 1'b0, data: 8'h00});
    exp_q.push_back('{err: 1'b0, data: 8'hFF});
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    drive_bit(1'b1, 4);
    checks++;
    if (out_cnt !== n0 + 2 || exp_q.size() != 0) begin
      failures++; $display("FAIL back_to_back_count got %0d want 2", out_cnt - n0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] part;
    int n0;
    part = 8'h96;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(part[i], 16);
    drive_bit(part[4], 8);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if ({bus, rx_done, frame_err} !== 10'b0) begin
      failures++; $display("FAIL mid_reset_outputs got bus=%02h rx_done=%0b frame_err=%0b want 00 0 0",
                           bus, rx_done, frame_err);
    end
    @(negedge clk) rst_n = 1'b1;
    drive_bit(1'b1, 20);
    n0 = out_cnt;
    exp_q.push_back('{err: 1'b0, data: 8'h5A});
    send_frame(8'h5A, 1'b1, -1);
    drive_bit(1'b1, 4);
    checks++;
    if (out_cnt !== n0 + 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL after_reset_count got %0d want 1", out_cnt - n0);
    end
  endtask

  task automatic test_tick_pause();
    int n0;
    n0 = out_cnt;
    exp_q.push_back('{err: 1'b0, data: 8'hC3});
    send_frame(8'hC3, 1'b1, 3);
    drive_bit(1'b1, 4);
    checks++;
    if (out_cnt !== n0 + 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL tick_pause_count got %0d want 1", out_cnt - n0);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    int n0;
    n0 = out_cnt;
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back('{err: 1'b0, data: d});
      send_frame(d, 1'b1, -1);
    end
    drive_bit(1'b1, 4);
    checks++;
    if (out_cnt !== n0 + 3 || exp_q.size() != 0) begin
      failures++; $display("FAIL random_count got %0d want 3", out_cnt - n0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_tick_pause();
    test_random_frames();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
